// File: rtl/leg_pkg.sv
// Shared types and constants for the fetch stage.
// Supplies default DATA_WIDTH and NOP opcode macros when not set by the build.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef NOP
`define NOP 7'b0010011
`endif

package leg_pkg;

    typedef enum logic [1:0] {
        FETCH,
        ISSUE,
        HALT
    } fetch_state_t;

    localparam int INST_BYTES = 4;

    localparam logic [31:0] NOP_INST = {25'd0, `NOP};

endpackage

// File: rtl/fetch_unit.sv
// Byte-serial instruction fetch and issue stage feeding execute.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned committed PC halts with o_fault.
module fetch_unit
    import leg_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    output logic [ADDR_WIDTH-1:0]  o_mem_addr,
    output logic                   o_mem_read,
    input  logic [`DATA_WIDTH-1:0] i_mem_data,
    input  logic                   i_mem_ready,
    output logic [31:0]            o_inst,
    output logic [ADDR_WIDTH-1:0]  o_pc,
    input  logic                   i_exec_ready,
    input  logic                   i_pc_change,
    input  logic [ADDR_WIDTH-1:0]  i_new_pc,
    input  logic                   i_invalid_inst,
    output logic                   o_halted,
    output logic                   o_fault,
    output logic [31:0]            o_retired
);

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(INST_BYTES);
    localparam logic [1:0] LAST_BYTE = 2'(INST_BYTES - 1);

    fetch_state_t          state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [1:0]            byte_q;
    logic [31:0]           inst_q;
    logic [31:0]           inst_out_q;
    logic                  mem_read_q;
    logic                  halted_q;
    logic [31:0]           retired_q;
    logic [ADDR_WIDTH-1:0] next_pc_d;

    always_comb begin
        next_pc_d = i_pc_change ? i_new_pc : pc_q + STEP;
    end

    assign o_mem_addr = (state_q == FETCH) ? pc_q + ADDR_WIDTH'(byte_q) : '0;
    assign o_mem_read = mem_read_q;
    assign o_inst     = inst_out_q;
    assign o_pc       = pc_q;
    assign o_halted   = halted_q;
    assign o_retired  = retired_q;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q;
    assign o_fault = fault_q;
`else
    assign o_fault = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            byte_q     <= '0;
            inst_q     <= '0;
            inst_out_q <= NOP_INST;
            mem_read_q <= 1'b1;
            halted_q   <= 1'b0;
            retired_q  <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (i_mem_ready) begin
                        inst_q[{byte_q, 3'b000} +: 8] <= i_mem_data;
                        byte_q <= byte_q + 2'd1;
                        if (byte_q == LAST_BYTE) begin
                            // Last byte goes straight to the output register
                            state_q    <= ISSUE;
                            mem_read_q <= 1'b0;
                            inst_out_q <= {i_mem_data, inst_q[23:0]};
                        end
                    end
                end
                ISSUE: begin
                    if (i_invalid_inst) begin
                        state_q    <= HALT;
                        halted_q   <= 1'b1;
                        inst_out_q <= NOP_INST;
                    end else if (i_exec_ready) begin
                        pc_q       <= next_pc_d;
                        retired_q  <= retired_q + 32'd1;
                        inst_out_q <= NOP_INST;
`ifdef FETCH_MISALIGN_TRAP_EN
                        if (next_pc_d[1:0] != 2'b00) begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                            fault_q  <= 1'b1;
                        end else begin
                            state_q    <= FETCH;
                            mem_read_q <= 1'b1;
                        end
`else
                        state_q    <= FETCH;
                        mem_read_q <= 1'b1;
`endif
                    end
                end
                HALT: begin
                end
                default: begin
                    state_q <= HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with a byte-memory reference model.
// Build with FETCH_MISALIGN_TRAP_EN to exercise the trap path.
module tb_fetch_unit;

    localparam logic [31:0] NOP_W = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic [7:0]  mem_data;
    logic        mem_ready = 1'b1;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        exec_ready = 1'b0;
    logic        pc_change = 1'b0;
    logic [31:0] new_pc = '0;
    logic        invalid_inst = 1'b0;
    logic        halted;
    logic        fault;
    logic [31:0] retired;

    logic [7:0]  mem [256];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] exp_pc = '0;
    logic [31:0] exp_ret = '0;

    always #5 clk = ~clk;

    assign mem_data = mem[mem_addr[7:0]];

    fetch_unit dut (
        .i_clk(clk), .i_rst(rst),
        .o_mem_addr(mem_addr), .o_mem_read(mem_read),
        .i_mem_data(mem_data), .i_mem_ready(mem_ready),
        .o_inst(inst), .o_pc(pc),
        .i_exec_ready(exec_ready), .i_pc_change(pc_change),
        .i_new_pc(new_pc), .i_invalid_inst(invalid_inst),
        .o_halted(halted), .o_fault(fault), .o_retired(retired)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {mem[b + 8'd3], mem[b + 8'd2], mem[b + 8'd1], mem[b]};
    endfunction

    task automatic wait_issue(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!mem_read && !halted) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL issue_timeout: mem_read=%0b required 0", mem_read);
        end
    endtask

    task automatic commit(input logic chg, input logic [31:0] npc);
        exec_ready = 1'b1;
        pc_change  = chg;
        new_pc     = npc;
        @(negedge clk);
        exec_ready = 1'b0;
        pc_change  = 1'b0;
        new_pc     = $urandom;
        exp_pc  = chg ? npc : exp_pc + 32'd4;
        exp_ret = exp_ret + 32'd1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #1;
        n_cmp++; if (inst !== NOP_W) begin n_fail++; $display("FAIL rst_inst: got %h req %h", inst, NOP_W); end
        n_cmp++; if (pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h req 0", pc); end
        n_cmp++; if (retired !== 32'h0) begin n_fail++; $display("FAIL rst_ret: got %0d req 0", retired); end
        n_cmp++; if (halted !== 1'b0 || fault !== 1'b0) begin n_fail++; $display("FAIL rst_flags: got %b%b req 00", halted, fault); end
        n_cmp++; if (mem_read !== 1'b1 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mem: got %b/%h req 1/0", mem_read, mem_addr); end
        @(negedge clk);
        rst = 1'b0;
        exp_pc = '0;
        exp_ret = '0;
    endtask

    task automatic test_first_fetch;
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (mem_addr !== 32'(k) || mem_read !== 1'b1 || inst !== NOP_W) begin
                n_fail++;
                $display("FAIL first_byte%0d: got %h/%b/%h req %h/1/%h", k, mem_addr, mem_read, inst, k, NOP_W);
            end
            @(negedge clk);
        end
        n_cmp++; if (inst !== 32'h0010_0513) begin n_fail++; $display("FAIL first_inst: got %h req 00100513", inst); end
        n_cmp++; if (pc !== 32'h0 || mem_read !== 1'b0 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL first_issue: got %h/%b/%h req 0/0/0", pc, mem_read, mem_addr); end
    endtask

    task automatic test_sequential;
        bit ok;
        commit(1'b0, 32'h0);
        n_cmp++; if (mem_addr !== 32'h4 || mem_read !== 1'b1) begin n_fail++; $display("FAIL seq_addr: got %h/%b req 4/1", mem_addr, mem_read); end
        n_cmp++; if (retired !== 32'd1) begin n_fail++; $display("FAIL seq_ret: got %0d req 1", retired); end
        wait_issue(ok);
        n_cmp++; if (inst !== word_at(32'h4) || pc !== 32'h4) begin n_fail++; $display("FAIL seq_inst: got %h@%h req %h@4", inst, pc, word_at(32'h4)); end
    endtask

    task automatic test_branch;
        bit ok;
        commit(1'b1, 32'h40);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (mem_addr !== 32'h40 + 32'(k)) begin n_fail++; $display("FAIL br_addr%0d: got %h req %h", k, mem_addr, 32'h40 + 32'(k)); end
            @(negedge clk);
        end
        wait_issue(ok);
        n_cmp++; if (inst !== word_at(32'h40) || pc !== 32'h40 || retired !== exp_ret) begin n_fail++; $display("FAIL br_issue: got %h@%h r%0d req %h@40 r%0d", inst, pc, retired, word_at(32'h40), exp_ret); end
    endtask

    task automatic test_wait_states;
        bit ok;
        commit(1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (mem_addr !== 32'h46 || inst !== NOP_W) begin n_fail++; $display("FAIL ws_hold%0d: got %h/%h req 46/%h", k, mem_addr, inst, NOP_W); end
            @(negedge clk);
        end
        mem_ready = 1'b1;
        wait_issue(ok);
        n_cmp++; if (inst !== word_at(32'h44) || pc !== 32'h44) begin n_fail++; $display("FAIL ws_word: got %h@%h req %h@44", inst, pc, word_at(32'h44)); end
    endtask

    task automatic test_wrap;
        bit ok;
        commit(1'b1, 32'hFFFF_FFFC);
        n_cmp++; if (mem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr: got %h req fffffffc", mem_addr); end
        wait_issue(ok);
        commit(1'b0, 32'h0);
        n_cmp++; if (mem_addr !== 32'h0 || pc !== 32'h0) begin n_fail++; $display("FAIL wrap_next: got %h/%h req 0/0", mem_addr, pc); end
        wait_issue(ok);
        n_cmp++; if (inst !== 32'h0010_0513 || retired !== exp_ret) begin n_fail++; $display("FAIL wrap_inst: got %h r%0d req 00100513 r%0d", inst, retired, exp_ret); end
    endtask

    task automatic test_random;
        int nb;
        int guard;
        logic rdy;
        for (int n = 0; n < 24; n++) begin
            nb = 0;
            guard = 0;
            while (mem_read && guard < 60) begin
                n_cmp++;
                if (mem_addr !== exp_pc + 32'(nb)) begin n_fail++; $display("FAIL rnd_addr: got %h req %h", mem_addr, exp_pc + 32'(nb)); end
                rdy = ($urandom_range(0, 3) != 0);
                mem_ready = rdy;
                @(negedge clk);
                if (rdy) nb++;
                guard++;
            end
            mem_ready = 1'b1;
            n_cmp++;
            if (nb != 4 || inst !== word_at(exp_pc) || pc !== exp_pc || retired !== exp_ret) begin
                n_fail++;
                $display("FAIL rnd_issue: got %h@%h r%0d nb%0d req %h@%h r%0d nb4", inst, pc, retired, nb, word_at(exp_pc), exp_pc, exp_ret);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ($urandom_range(0, 2) == 0)
                commit(1'b1, {24'd0, 6'($urandom), 2'b00});
            else
                commit(1'b0, 32'h0);
        end
    endtask

    task automatic test_misalign;
        bit ok;
        wait_issue(ok);
        commit(1'b1, 32'h42);
`ifdef FETCH_MISALIGN_TRAP_EN
        n_cmp++; if (fault !== 1'b1 || halted !== 1'b1) begin n_fail++; $display("FAIL trap_flags: got %b%b req 11", fault, halted); end
        n_cmp++; if (pc !== 32'h42 || retired !== exp_ret || mem_read !== 1'b0) begin n_fail++; $display("FAIL trap_state: got %h r%0d rd%b req 42 r%0d rd0", pc, retired, mem_read, exp_ret); end
`else
        n_cmp++; if (mem_addr !== 32'h42 || fault !== 1'b0) begin n_fail++; $display("FAIL mis_addr: got %h f%b req 42 f0", mem_addr, fault); end
        wait_issue(ok);
        n_cmp++; if (inst !== word_at(32'h42) || pc !== 32'h42) begin n_fail++; $display("FAIL mis_word: got %h@%h req %h@42", inst, pc, word_at(32'h42)); end
`endif
    endtask

    task automatic test_reset_midfetch;
        bit ok;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (mem_addr !== 32'h2) begin n_fail++; $display("FAIL mid_pre: got %h req 2", mem_addr); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (mem_addr !== 32'h0 || inst !== NOP_W || halted !== 1'b0 || fault !== 1'b0 || retired !== 32'h0) begin
            n_fail++; $display("FAIL mid_rst: got %h/%h/%b%b/%0d req 0/%h/00/0", mem_addr, inst, halted, fault, retired, NOP_W);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_pc = '0;
        exp_ret = '0;
        wait_issue(ok);
        n_cmp++; if (inst !== 32'h0010_0513 || pc !== 32'h0) begin n_fail++; $display("FAIL mid_refetch: got %h@%h req 00100513@0", inst, pc); end
    endtask

    task automatic test_stall_halt;
        logic [31:0] w;
        commit(1'b0, 32'h0);
        mem_ready = 1'b1;
        repeat (4) @(negedge clk);
        w = word_at(32'h4);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (inst !== w || pc !== 32'h4) begin n_fail++; $display("FAIL stall%0d: got %h@%h req %h@4", k, inst, pc, w); end
            if (k < 3) @(negedge clk);
        end
        invalid_inst = 1'b1;
        exec_ready = 1'b1;
        @(negedge clk);
        invalid_inst = 1'b0;
        exec_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (halted !== 1'b1 || inst !== NOP_W || mem_read !== 1'b0 || retired !== exp_ret || pc !== 32'h4) begin
                n_fail++; $display("FAIL halt%0d: got %b/%h/%b/r%0d/%h req 1/%h/0/r%0d/4", k, halted, inst, mem_read, retired, pc, NOP_W, exp_ret);
            end
            exec_ready = $urandom_range(0, 1) == 1;
            pc_change = $urandom_range(0, 1) == 1;
            @(negedge clk);
        end
        exec_ready = 1'b0;
        pc_change = 1'b0;
    endtask

    initial begin
        bit ok;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
        @(negedge clk);
        test_reset;
        test_first_fetch;
        test_sequential;
        test_branch;
        test_wait_states;
        test_wrap;
        commit(1'b0, 32'h0);
        test_random;
        test_misalign;
        test_reset_midfetch;
        test_stall_halt;
        ok = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
